// File: rtl/board_input_conditioner_if.sv
// Pin-side bundle for board_input_conditioner: raw board pins in, conditioned
// levels and edge pulses out.
interface board_input_conditioner_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] raw_i;
  logic [NUM_CH-1:0] level_o;
  logic [NUM_CH-1:0] rise_o;
  logic [NUM_CH-1:0] fall_o;
  logic              any_edge_o;

  modport master (
    output raw_i,
    input  level_o, rise_o, fall_o, any_edge_o
  );

  modport slave (
    input  raw_i,
    output level_o, rise_o, fall_o, any_edge_o
  );
endinterface

// File: rtl/board_input_conditioner.sv
// Per-channel synchroniser, polarity normalisation and prescaled debounce for
// board buttons/switches, producing clean levels plus one-cycle edge pulses.
module board_input_conditioner #(
  parameter int                NUM_CH         = 4,
  parameter int                SYNC_STAGES    = 2,
  parameter int                PRESCALE       = 100,
  parameter int                DEBOUNCE_TICKS = 1000,
  parameter logic [NUM_CH-1:0] INVERT         = {NUM_CH{1'b0}},
  parameter logic [NUM_CH-1:0] RESET_VALUE    = {NUM_CH{1'b0}}
) (
  input  logic                      ref_clk,
  input  logic                      pad_reset,
  board_input_conditioner_if.slave  bus
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic {STABLE, COUNTING} state_e;

  logic [NUM_CH-1:0] sync_ff [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_q;
  logic [PRE_W-1:0]  pre_q;
  logic              tick;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] mismatch;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic              any_q, any_d;

  // NOTE: the synchroniser chain is reset (to the pre-inversion image of
  // RESET_VALUE) so no spurious mismatch appears right after reset.
  always_ff @(posedge ref_clk) begin
    if (pad_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_ff[s] <= RESET_VALUE ^ INVERT;
    end else begin
      sync_ff[0] <= bus.raw_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_ff[s] <= sync_ff[s-1];
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1] ^ INVERT;

  // Free-running prescaler; with PRESCALE=1 the compare is always true.
  always_ff @(posedge ref_clk) begin
    if (pad_reset)          pre_q <= '0;
    else if (pre_q == PRE_LAST) pre_q <= '0;
    else                    pre_q <= pre_q + PRE_W'(1);
  end

  assign tick     = (pre_q == PRE_LAST);
  assign mismatch = sync_q ^ level_q;

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ref_clk) begin
    if (pad_reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= STABLE;
        cnt_q[ch]   <= '0;
      end
      level_q <= RESET_VALUE;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    accept = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      unique case (state_q[ch])
        STABLE: begin
          // cnt is 0 here, so the final-tick test only fires when DEBOUNCE_TICKS=1
          if (mismatch[ch]) begin
            if (tick && cnt_q[ch] == CNT_LAST) begin
              accept[ch] = 1'b1;
            end else begin
              state_d[ch] = COUNTING;
              if (tick) cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
          end
        end
        COUNTING: begin
          if (!mismatch[ch]) begin
            state_d[ch] = STABLE;
            cnt_d[ch]   = '0;
          end else if (tick) begin
            if (cnt_q[ch] == CNT_LAST) begin
              accept[ch]  = 1'b1;
              state_d[ch] = STABLE;
              cnt_d[ch]   = '0;
            end else begin
              cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    level_d = level_q ^ accept;
    rise_d  = accept & sync_q;
    fall_d  = accept & ~sync_q;
    any_d   = |accept;
  end

  assign bus.level_o    = level_q;
  assign bus.rise_o     = rise_q;
  assign bus.fall_o     = fall_q;
  assign bus.any_edge_o = any_q;

endmodule
